dmem_arbiter: RTL and testbench

//   Round-robin data-memory arbiter for the multicore top: NUM_CORES cores share one

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data_memory port among NUM_CORES cores, with a testbench bypass.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic [1:0]                    addr_mux_select,
  input  logic [ADDR_W-1:0]             tb_addr,
  input  logic                          tb_write,
  input  logic [DATA_W-1:0]             tb_wdata,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_grant,
  output logic [NUM_CORES-1:0]          core_rvalid,
  output logic [DATA_W-1:0]             core_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_write,
  output logic                          mem_read,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, TB} state_e;

  state_e                 state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       owner_q;
  logic [NUM_CORES-1:0]   grant_q;
  logic [NUM_CORES-1:0]   rvalid_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic [DATA_W-1:0]      mem_wdata_q;
  logic                   mem_write_q;
  logic                   mem_read_q;

  logic                   core_mode;
  logic                   found_d;
  logic [PTR_W-1:0]       winner_d;

  assign core_mode = (addr_mux_select == 2'b00) || (addr_mux_select == 2'b11);

  always_comb begin
    found_d  = 1'b0;
    winner_d = '0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found_d && core_req[i]) begin
        found_d  = 1'b1;
        winner_d = PTR_W'(i);
      end
    end
`else
    begin : rr_search
      int idx;
      idx = 0;
      // Search starts just after the last winner so every requester is reached within NUM_CORES grants.
      for (int i = 1; i <= NUM_CORES; i++) begin
        idx = (int'(ptr_q) + i) % NUM_CORES;
        if (!found_d && core_req[idx]) begin
          found_d  = 1'b1;
          winner_d = PTR_W'(idx);
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_W'(NUM_CORES - 1);
      owner_q     <= '0;
      grant_q     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      grant_q  <= '0;
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (!core_mode) begin
            state_q <= TB;
          end else if (found_d) begin
            owner_q           <= winner_d;
            ptr_q             <= winner_d;
            mem_addr_q        <= core_addr[winner_d*ADDR_W +: ADDR_W];
            mem_wdata_q       <= core_wdata[winner_d*DATA_W +: DATA_W];
            mem_write_q       <= core_we[winner_d];
            mem_read_q        <= ~core_we[winner_d];
            grant_q[winner_d] <= 1'b1;
            state_q           <= ACCESS;
          end
        end
        ACCESS: begin
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          state_q     <= mem_write_q ? IDLE : WAIT;
        end
        WAIT: begin
          rdata_q           <= mem_rdata;
          rvalid_q[owner_q] <= 1'b1;
          state_q           <= core_mode ? IDLE : TB;
        end
        TB: begin
          if (core_mode) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // TB mode hands the memory port straight to the testbench, bypassing the registers.
  always_comb begin
    if (state_q == TB) begin
      mem_addr  = tb_addr;
      mem_wdata = tb_wdata;
      mem_write = tb_write & (addr_mux_select == 2'b01);
      mem_read  = (addr_mux_select == 2'b10);
    end else begin
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
      mem_write = mem_write_q;
      mem_read  = mem_read_q;
    end
  end

  assign core_grant  = grant_q;
  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign busy        = (state_q == ACCESS) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a data_memory model and grant/read-data scoreboards.
module tb_dmem_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk;
  logic              RESET;
  logic [1:0]        addr_mux_select;
  logic [AW-1:0]     tb_addr;
  logic              tb_write;
  logic [DW-1:0]     tb_wdata;
  logic [NC-1:0]     core_req;
  logic [NC-1:0]     core_we;
  logic [NC*AW-1:0]  core_addr;
  logic [NC*DW-1:0]  core_wdata;
  logic [NC-1:0]     core_grant;
  logic [NC-1:0]     core_rvalid;
  logic [DW-1:0]     core_rdata;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DW-1:0]     mem_rdata;
  logic              busy;

  dmem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .RESET(RESET), .addr_mux_select(addr_mux_select),
    .tb_addr(tb_addr), .tb_write(tb_write), .tb_wdata(tb_wdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_grant(core_grant), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous data_memory: read data appears the cycle after mem_read.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
  end

  typedef struct packed {
    logic [3:0]    core;
    logic [DW-1:0] data;
  } rd_t;

  int      gq[$];
  rd_t     rq[$];
  int      checks;
  int      passes;
  int      grants_seen;
  logic [NC-1:0] keep_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_core(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_we[k]             = we;
    core_addr[k*AW +: AW]  = a;
    core_wdata[k*DW +: DW] = d;
  endtask

  task automatic step();
    int  g;
    rd_t e;
    @(posedge clk);
    #1;
    if (|core_grant) begin
      grants_seen++;
      if (gq.size() == 0) begin
        check("unexpected_grant", 32'(core_grant), 32'h0);
      end else begin
        g = gq.pop_front();
        check("grant", 32'(core_grant), 32'(4'b0001 << g));
      end
    end
    if (|core_rvalid) begin
      if (rq.size() == 0) begin
        check("unexpected_rvalid", 32'(core_rvalid), 32'h0);
      end else begin
        e = rq.pop_front();
        check("rvalid", 32'(core_rvalid), 32'(4'b0001 << e.core));
        check("rdata", 32'(core_rdata), 32'(e.data));
      end
    end
    if (mem_read || mem_write) check("rw_exclusive", 32'(mem_read & mem_write), 32'h0);
    core_req = core_req & ~(core_grant & ~keep_req);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (gq.size() != 0 || rq.size() != 0); i++) step();
    check("grant_queue_empty", 32'(gq.size()), 32'h0);
    check("read_queue_empty", 32'(rq.size()), 32'h0);
  endtask

  initial begin
    checks = 0; passes = 0; grants_seen = 0; keep_req = '0;
    RESET = 1'b1; addr_mux_select = 2'b00; tb_addr = '0; tb_write = 1'b0; tb_wdata = '0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    #3;
    check("rst_grant", 32'(core_grant), 32'h0);
    check("rst_rvalid", 32'(core_rvalid), 32'h0);
    check("rst_rdata", 32'(core_rdata), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_rw", 32'({mem_read, mem_write}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    RESET = 1'b0;

    // Testbench bypass: write 0x1234 @0x10, then read it back.
    addr_mux_select = 2'b01; tb_addr = 16'h0010; tb_wdata = 16'h1234; tb_write = 1'b1;
    step();
    check("tb_mem_write", 32'(mem_write), 32'h1);
    check("tb_mem_addr", 32'(mem_addr), 32'h0010);
    step();
    tb_write = 1'b0; addr_mux_select = 2'b10;
    #1;
    check("tb_mem_read", 32'({mem_read, mem_write}), 32'h2);
    step();
    check("tb_mem_rdata", 32'(mem_rdata), 32'h1234);
    addr_mux_select = 2'b00;
    step();

    // Core 2 read alone; core 1 raises and drops req while the FSM is busy.
    set_core(2, 1'b0, 16'h0010, 16'h0);
    core_req[2] = 1'b1;
    gq.push_back(2); rq.push_back('{core: 4'd2, data: 16'h1234});
    step();
    check("c2_grant_cycle1", 32'(core_grant), 32'h4);
    check("c2_busy", 32'(busy), 32'h1);
    set_core(1, 1'b1, 16'h0050, 16'hDEAD);
    core_req[1] = 1'b1;
    step();
    core_req[1] = 1'b0;
    check("c2_no_rvalid_yet", 32'(core_rvalid), 32'h0);
    step();
    check("c2_rvalid_cycle2", 32'(core_rvalid), 32'h4);
    drain(20);

    // Core 1 writes 0xBEEF @0x20, core 3 reads it back.
    set_core(1, 1'b1, 16'h0020, 16'hBEEF);
    core_req[1] = 1'b1;
    gq.push_back(1);
    drain(20);
    set_core(3, 1'b0, 16'h0020, 16'h0);
    core_req[3] = 1'b1;
    gq.push_back(3); rq.push_back('{core: 4'd3, data: 16'hBEEF});
    drain(20);
    check("rdata_hold", 32'(core_rdata), 32'hBEEF);

    // Mode leaves core mode during WAIT of a core 0 read.
    set_core(0, 1'b0, 16'h0020, 16'h0);
    core_req[0] = 1'b1;
    gq.push_back(0); rq.push_back('{core: 4'd0, data: 16'hBEEF});
    step();
    step();
    addr_mux_select = 2'b01; tb_addr = 16'h0030; tb_write = 1'b0;
    step();
    check("wait_to_tb_rq", 32'(rq.size()), 32'h0);
    check("wait_to_tb_addr", 32'(mem_addr), 32'h0030);
    check("wait_to_tb_busy", 32'(busy), 32'h0);
    addr_mux_select = 2'b00;
    step();
    drain(20);

    // Reset during ACCESS aborts the read.
    set_core(2, 1'b0, 16'h0010, 16'h0);
    core_req[2] = 1'b1;
    gq.push_back(2);
    step();
    RESET = 1'b1;
    #1;
    check("rst_access_grant", 32'(core_grant), 32'h0);
    check("rst_access_busy", 32'(busy), 32'h0);
    check("rst_access_rw", 32'({mem_read, mem_write}), 32'h0);
    core_req = '0;
    @(posedge clk); #1;
    RESET = 1'b0;
    check("rst_access_queue", 32'(gq.size()), 32'h0);

    // All cores request continuously, cores 0/2 read and 1/3 write.
    set_core(0, 1'b0, 16'h0010, 16'h0);
    set_core(1, 1'b1, 16'h0041, 16'hA001);
    set_core(2, 1'b0, 16'h0010, 16'h0);
    set_core(3, 1'b1, 16'h0043, 16'hA003);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) begin
      gq.push_back(0);
      rq.push_back('{core: 4'd0, data: 16'h1234});
    end
`else
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
    rq.push_back('{core: 4'd0, data: 16'h1234});
    rq.push_back('{core: 4'd2, data: 16'h1234});
    rq.push_back('{core: 4'd0, data: 16'h1234});
`endif
    keep_req = 4'hF;
    core_req = 4'hF;
    grants_seen = 0;
    for (int i = 0; i < 200 && grants_seen < 5; i++) step();
    core_req = '0;
    keep_req = '0;
    check("rr_grant_count", 32'(grants_seen), 32'd5);
    drain(20);
    for (int i = 0; i < 4; i++) step();
    check("final_idle_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
